rv32i_mc_ctrl: RTL and testbench

Multi-cycle control FSM for the rv32i core. It fetches each instruction over a req/ack instruction-memory port and holds it in the instruction register that drives the decoder. It sequences ALU and data-memory use, then pulses the register-file write enable in writeback. It owns the PC and a retired-instruction counter, and sits beside the decoder and register file in the core top level.

---
 rtl/rv32i_mc_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_rv32i_mc_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_mc_ctrl
// Brief    : Multi-cycle control FSM for the rv32i core. Fetches over a
//            req/ack port into the instruction register, sequences ALU and
//            data-memory use, strobes register-file writeback, and owns the
//            PC and the retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_mc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      ins,
  input  logic [31:0]      imm,
  input  logic [31:0]      alu_result,
  input  logic             branch_taken,
  output logic             alu_a_pc,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [31:0]      dmem_addr,
  input  logic             dmem_ack,
  output logic             wrt_en,
  output logic [1:0]       wb_sel,
  output logic [31:0]      pc,
  output logic [CNT_W-1:0] instret,
  output logic             halted,
  output logic             illegal
);

  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_opimm  = 7'b0010011;
  localparam logic [6:0] c_op_op     = 7'b0110011;
  localparam logic [6:0] c_op_fence  = 7'b0001111;
  localparam logic [6:0] c_op_system = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_live;
  logic [31:0]      r_pc;
  logic [31:0]      r_ins;
  logic [CNT_W-1:0] r_instret;
  logic             r_halted;
  logic             r_illegal;

  logic [6:0]  w_opcode;
  logic        w_is_lui, w_is_auipc, w_is_jal, w_is_jalr, w_is_branch;
  logic        w_is_load, w_is_store, w_is_opimm, w_is_op, w_is_fence;
  logic        w_is_system, w_is_mem, w_legal, w_writes_rd;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_imm;
  logic [31:0] w_next_pc;
  logic        w_misaligned;

  assign w_opcode    = r_ins[6:0];
  assign w_is_lui    = (w_opcode == c_op_lui);
  assign w_is_auipc  = (w_opcode == c_op_auipc);
  assign w_is_jal    = (w_opcode == c_op_jal);
  assign w_is_jalr   = (w_opcode == c_op_jalr);
  assign w_is_branch = (w_opcode == c_op_branch);
  assign w_is_load   = (w_opcode == c_op_load);
  assign w_is_store  = (w_opcode == c_op_store);
  assign w_is_opimm  = (w_opcode == c_op_opimm);
  assign w_is_op     = (w_opcode == c_op_op);
  assign w_is_fence  = (w_opcode == c_op_fence);
  assign w_is_system = (w_opcode == c_op_system);
  assign w_is_mem    = w_is_load | w_is_store;

  assign w_legal = w_is_lui | w_is_auipc | w_is_jal | w_is_jalr | w_is_branch |
                   w_is_load | w_is_store | w_is_opimm | w_is_op | w_is_fence;

  // Writes to x0 are never strobed so the register file needs no x0 guard.
  assign w_writes_rd = (w_is_lui | w_is_auipc | w_is_jal | w_is_jalr |
                        w_is_op | w_is_opimm | w_is_load) && (r_ins[11:7] != 5'd0);

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_pc_imm   = r_pc + imm;

  // Next-PC selection for the writeback cycle.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (w_is_jal) begin
      w_next_pc = w_pc_imm;
    end else if (w_is_jalr) begin
      w_next_pc = alu_result & 32'hFFFF_FFFE;
    end else if (w_is_branch && branch_taken) begin
      w_next_pc = w_pc_imm;
    end
  end

  assign w_misaligned = (w_next_pc[1:0] != 2'b00);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and Moore strobe decode; r_live keeps imem_req low until the
  // first edge after reset release so no request is visible during reset.
  always_comb begin
    w_next_state = r_state;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    wrt_en       = 1'b0;
    alu_a_pc     = 1'b0;
    wb_sel       = 2'd0;
    case (r_state)
      S_FETCH: begin
        imem_req = r_live;
        if (r_live && imem_ack) begin
          w_next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        w_next_state = w_legal ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        alu_a_pc     = w_is_auipc | w_is_jal;
        w_next_state = w_is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = w_is_store;
        if (dmem_ack) begin
          w_next_state = S_WB;
        end
      end
      S_WB: begin
        // Operand A stays on the PC so the AUIPC result is still valid on
        // alu_result while the register file captures it.
        alu_a_pc = w_is_auipc | w_is_jal;
        wrt_en   = w_writes_rd & ~w_misaligned;
        if (w_is_lui) begin
          wb_sel = 2'd3;
        end else if (w_is_load) begin
          wb_sel = 2'd1;
        end else if (w_is_jal || w_is_jalr) begin
          wb_sel = 2'd2;
        end else begin
          wb_sel = 2'd0;
        end
        w_next_state = w_misaligned ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        w_next_state = S_HALT;
      end
      default: begin
        // Unused encodings park safely in HALT.
        w_next_state = S_HALT;
      end
    endcase
  end

  // Architectural state: instruction register, PC, counter and sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_live    <= 1'b0;
      r_pc      <= RESET_PC;
      r_ins     <= 32'd0;
      r_instret <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        S_FETCH: begin
          if (r_live && imem_ack) begin
            r_ins <= imem_rdata;
          end
        end
        S_DECODE: begin
          if (w_is_system) begin
            r_halted <= 1'b1;
          end else if (!w_legal) begin
            r_illegal <= 1'b1;
          end
        end
        S_WB: begin
          if (w_misaligned) begin
            r_illegal <= 1'b1;
          end else begin
            r_pc      <= w_next_pc;
            r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign imem_addr = r_pc;
  assign dmem_addr = dmem_req ? alu_result : 32'd0;
  assign ins       = r_ins;
  assign pc        = r_pc;
  assign instret   = r_instret;
  assign halted    = r_halted;
  assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_mc_ctrl
// Brief    : Self-checking bench for rv32i_mc_ctrl: directed scenarios plus
//            randomized instruction streams against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_mc_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ins;
  logic [31:0] imm;
  logic [31:0] alu_result;
  logic        branch_taken;
  logic        alu_a_pc;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic        dmem_ack;
  logic        wrt_en;
  logic [1:0]  wb_sel;
  logic [31:0] pc;
  logic [31:0] instret;
  logic        halted;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instret;

  rv32i_mc_ctrl #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .ins          (ins),
    .imm          (imm),
    .alu_result   (alu_result),
    .branch_taken (branch_taken),
    .alu_a_pc     (alu_a_pc),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_ack     (dmem_ack),
    .wrt_en       (wrt_en),
    .wb_sel       (wb_sel),
    .pc           (pc),
    .instret      (instret),
    .halted       (halted),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit is_legal(input logic [6:0] op);
    return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                      OP_LOAD, OP_STORE, OP_OPIMM, OP_OP, OP_FENCE};
  endfunction

  function automatic bit writes_rd(input logic [6:0] op);
    return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OP, OP_OPIMM, OP_LOAD};
  endfunction

  function automatic logic [1:0] ref_sel(input logic [6:0] op);
    if (op == OP_LUI) return 2'd3;
    if (op == OP_LOAD) return 2'd1;
    if (op == OP_JAL || op == OP_JALR) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] ref_next_pc(input logic [6:0] op, input logic [31:0] cur,
                                              input logic [31:0] imm_v, input logic [31:0] alu_v,
                                              input logic tk);
    if (op == OP_JAL) return cur + imm_v;
    if (op == OP_JALR) return alu_v & 32'hFFFF_FFFE;
    if (op == OP_BRANCH && tk) return cur + imm_v;
    return cur + 32'd4;
  endfunction

  // Hold reset, check the reset image, release, and land one tick after the
  // first rising edge with reset deasserted.
  task automatic do_reset();
    rst          = 1'b0;
    imem_ack     = 1'b0;
    imem_rdata   = 32'd0;
    dmem_ack     = 1'b0;
    imm          = 32'd0;
    alu_result   = 32'd0;
    branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_pc", pc, RST_PC);
    check_eq("rst_instret", instret, 32'd0);
    check_eq("rst_ins", ins, 32'd0);
    check_eq("rst_imem_req", 32'(imem_req), 32'd0);
    check_eq("rst_strobes", 32'({dmem_req, dmem_we, wrt_en, alu_a_pc}), 32'd0);
    check_eq("rst_wb_sel", 32'(wb_sel), 32'd0);
    check_eq("rst_flags", 32'({halted, illegal}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    m_pc      = RST_PC;
    m_instret = 32'd0;
  endtask

  // Drive one instruction through the controller and compare each phase with
  // the model. Returns ended=1 if the instruction stopped the core.
  task automatic run_instr(input logic [31:0] word, input logic [31:0] imm_v,
                           input logic [31:0] alu_v, input logic tk,
                           input int ilat, input int dlat, output bit ended);
    logic [6:0]  op;
    logic [31:0] npc;
    bit          mis;
    op    = word[6:0];
    ended = 1'b0;
    for (int i = 0; i < ilat; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      #1;
      check_eq("fetch_wait_req", 32'(imem_req), 32'd1);
      check_eq("fetch_wait_addr", imem_addr, m_pc);
      tick();
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    #1;
    check_eq("fetch_req", 32'(imem_req), 32'd1);
    check_eq("fetch_addr", imem_addr, m_pc);
    tick();
    // decode cycle; stray acks must be ignored
    imem_ack     = 1'($urandom_range(0, 1));
    imem_rdata   = $urandom;
    dmem_ack     = 1'($urandom_range(0, 1));
    imm          = imm_v;
    alu_result   = alu_v;
    branch_taken = tk;
    #1;
    check_eq("ins_reg", ins, word);
    check_eq("dec_strobes", 32'({imem_req, dmem_req, wrt_en}), 32'd0);
    if (op == OP_SYSTEM || !is_legal(op)) begin
      tick();
      check_eq("stop_halted", 32'(halted), 32'(op == OP_SYSTEM));
      check_eq("stop_illegal", 32'(illegal), 32'(op != OP_SYSTEM));
      check_eq("stop_strobes", 32'({imem_req, dmem_req, wrt_en}), 32'd0);
      check_eq("stop_instret", instret, m_instret);
      ended = 1'b1;
      return;
    end
    tick();
    // execute cycle
    #1;
    check_eq("exec_alu_a_pc", 32'(alu_a_pc), 32'(op == OP_AUIPC || op == OP_JAL));
    check_eq("exec_strobes", 32'({imem_req, dmem_req, wrt_en}), 32'd0);
    tick();
    if (op == OP_LOAD || op == OP_STORE) begin
      for (int j = 0; j < dlat; j++) begin
        dmem_ack = 1'b0;
        #1;
        check_eq("mem_req", 32'(dmem_req), 32'd1);
        check_eq("mem_we", 32'(dmem_we), 32'(op == OP_STORE));
        check_eq("mem_addr", dmem_addr, alu_v);
        tick();
      end
      dmem_ack = 1'b1;
      #1;
      check_eq("mem_req_ack", 32'(dmem_req), 32'd1);
      check_eq("mem_we_ack", 32'(dmem_we), 32'(op == OP_STORE));
      tick();
      dmem_ack = 1'b0;
    end
    // writeback cycle
    npc = ref_next_pc(op, m_pc, imm_v, alu_v, tk);
    mis = (npc[1:0] != 2'b00);
    #1;
    check_eq("wb_wrt_en", 32'(wrt_en),
             32'(writes_rd(op) && (word[11:7] != 5'd0) && !mis));
    check_eq("wb_dmem_req", 32'(dmem_req), 32'd0);
    if (!mis) check_eq("wb_sel", 32'(wb_sel), 32'(ref_sel(op)));
    tick();
    if (mis) begin
      check_eq("mis_illegal", 32'(illegal), 32'd1);
      check_eq("mis_pc", pc, m_pc);
      check_eq("mis_instret", instret, m_instret);
      check_eq("mis_imem_req", 32'(imem_req), 32'd0);
      ended = 1'b1;
    end else begin
      m_pc      = npc;
      m_instret = m_instret + 32'd1;
      check_eq("ret_pc", pc, m_pc);
      check_eq("ret_instret", instret, m_instret);
      check_eq("next_fetch_req", 32'(imem_req), 32'd1);
      check_eq("next_fetch_addr", imem_addr, m_pc);
    end
  endtask

  // Once stopped, acks must be ignored and all state frozen.
  task automatic check_frozen(input logic [31:0] word);
    for (int k = 0; k < 3; k++) begin
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
      dmem_ack   = 1'b1;
      tick();
      check_eq("frz_pc", pc, m_pc);
      check_eq("frz_instret", instret, m_instret);
      check_eq("frz_ins", ins, word);
      check_eq("frz_strobes", 32'({imem_req, dmem_req, wrt_en, alu_a_pc}), 32'd0);
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  task automatic gen(output logic [31:0] word, output logic [31:0] imm_v,
                     output logic [31:0] alu_v, output logic tk);
    logic [6:0]  op;
    logic [31:0] t;
    logic [6:0]  ops [10];
    int          r;
    ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_OPIMM, OP_OP, OP_FENCE};
    r = int'($urandom_range(0, 99));
    if (r < 2) begin
      op = OP_SYSTEM;
    end else if (r < 4) begin
      do op = 7'($urandom_range(0, 127)); while (is_legal(op) || op == OP_SYSTEM);
    end else begin
      op = ops[$urandom_range(0, 9)];
    end
    t    = $urandom;
    word = {t[31:7], op};
    if ($urandom_range(0, 7) == 0) word[11:7] = 5'd0;
    t     = $urandom;
    imm_v = ($urandom_range(0, 19) == 0) ? {t[31:2], 2'b10} : {t[31:2], 2'b00};
    t     = $urandom;
    if (op == OP_JALR)
      alu_v = ($urandom_range(0, 9) == 0) ? {t[31:2], 2'b10} : {t[31:2], 1'b0, t[0]};
    else
      alu_v = t;
    tk = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          ended;
    logic [31:0] w, iv, av;
    logic        tk;

    // addi x1,x0,5 with zero-wait fetch
    do_reset();
    run_instr(32'h0050_0093, 32'd5, 32'd5, 1'b0, 0, 0, ended);
    check_eq("addi_continue", 32'(ended), 32'd0);
    // lw x2,0(x1) with data ack three cycles late
    run_instr(32'h0000_A103, 32'd0, 32'h0000_2000, 1'b0, 0, 3, ended);

    // taken branch at 0x104 -> 0x10C
    do_reset();
    run_instr(32'h0050_0093, 32'd5, 32'd5, 1'b0, 0, 0, ended);
    run_instr(32'h0020_8463, 32'd8, 32'd0, 1'b1, 1, 0, ended);
    check_eq("br_taken_pc", pc, 32'h0000_010C);
    // not-taken branch at 0x104 -> 0x108
    do_reset();
    run_instr(32'h0050_0093, 32'd5, 32'd5, 1'b0, 0, 0, ended);
    run_instr(32'h0020_8463, 32'd8, 32'd0, 1'b0, 2, 0, ended);
    check_eq("br_not_taken_pc", pc, 32'h0000_0108);

    // jalr to 0x203 -> 0x202 is misaligned
    do_reset();
    run_instr(32'h0000_80E7, 32'd0, 32'h0000_0203, 1'b0, 0, 0, ended);
    check_eq("jalr_mis_ended", 32'(ended), 32'd1);
    check_frozen(32'h0000_80E7);

    // ecall halts, 0x7F is illegal
    do_reset();
    run_instr(32'h0000_0073, 32'd0, 32'd0, 1'b0, 0, 0, ended);
    check_frozen(32'h0000_0073);
    do_reset();
    run_instr(32'h0000_007F, 32'd0, 32'd0, 1'b0, 0, 0, ended);
    check_frozen(32'h0000_007F);

    // asynchronous reset in the middle of a data access
    do_reset();
    run_instr(32'h0050_0093, 32'd5, 32'd5, 1'b0, 0, 0, ended);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_A103;
    tick();
    imem_ack   = 1'b0;
    alu_result = 32'h0000_0040;
    tick();
    tick();
    check_eq("mid_mem_req", 32'(dmem_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_dmem_req", 32'(dmem_req), 32'd0);
    check_eq("async_pc", pc, RST_PC);
    check_eq("async_instret", instret, 32'd0);
    check_eq("async_imem_req", 32'(imem_req), 32'd0);
    do_reset();
    run_instr(32'h0050_0093, 32'd5, 32'd5, 1'b0, 0, 0, ended);

    // randomized instruction streams
    for (int run = 0; run < 20; run++) begin
      do_reset();
      ended = 1'b0;
      for (int k = 0; k < 25 && !ended; k++) begin
        gen(w, iv, av, tk);
        run_instr(w, iv, av, tk, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), ended);
        if (ended) check_frozen(w);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
